// File: rtl/mult32_pkg.sv
// Shared types and constants for the sequential 32x32 multiplier controller.
// Content: FSM state enum, datapath widths, and a helper that checks whether
// the multiplier bytes above a row are all zero. Only the early-exit build
// calls that helper.
package mult32_pkg;

  localparam int unsigned MULT_BYTE_W = 8;
  localparam int unsigned MULT_ROWS   = 4;
  localparam int unsigned MULT_ROW_W  = 40;
  localparam int unsigned MULT_PROD_W = 64;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } mult_state_t;

  // True when every multiplier byte above row k is zero. Row 3 has no
  // bytes above it, so it always reports true.
  function automatic logic upper_bytes_zero(input logic [31:0] b, input logic [1:0] k);
    unique case (k)
      2'd0:    return b[31:8] == 24'd0;
      2'd1:    return b[31:16] == 16'd0;
      2'd2:    return b[31:24] == 8'd0;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mult32_seq_acc_if.sv
// Handshake and combiner bundle for mult32_seq_acc.
// Operand side:  in_valid, in_ready, a_in, b_in.
// Combiner side: pp_a..pp_d out to the row combiner, row_sum back from it.
// Result side:   out_valid, out_ready, product.
// Modport slave is the multiplier's view. Modport master is the
// environment's view, which includes the combiner.
interface mult32_seq_acc_if;

  logic                                in_valid;
  logic                                in_ready;
  logic [31:0]                         a_in;
  logic [31:0]                         b_in;
  logic [15:0]                         pp_a;
  logic [15:0]                         pp_b;
  logic [15:0]                         pp_c;
  logic [15:0]                         pp_d;
  logic [mult32_pkg::MULT_ROW_W-1:0]   row_sum;
  logic                                out_valid;
  logic                                out_ready;
  logic [mult32_pkg::MULT_PROD_W-1:0]  product;

  modport slave (
    input  in_valid, a_in, b_in, row_sum, out_ready,
    output in_ready, pp_a, pp_b, pp_c, pp_d, out_valid, product
  );

  modport master (
    output in_valid, a_in, b_in, row_sum, out_ready,
    input  in_ready, pp_a, pp_b, pp_c, pp_d, out_valid, product
  );

endinterface

// File: rtl/pp_gen8x32.sv
// Combinational partial-product generator.
// Multiplies each byte of the 32-bit multiplicand by one multiplier byte.
// Ports:
//   a_i    - multiplicand (32b)
//   bk_i   - current multiplier byte (8b)
//   pp_a_o - a_i[7:0]   * bk_i (16b)
//   pp_b_o - a_i[15:8]  * bk_i (16b)
//   pp_c_o - a_i[23:16] * bk_i (16b)
//   pp_d_o - a_i[31:24] * bk_i (16b)
module pp_gen8x32 (
  input  logic [31:0] a_i,
  input  logic [7:0]  bk_i,
  output logic [15:0] pp_a_o,
  output logic [15:0] pp_b_o,
  output logic [15:0] pp_c_o,
  output logic [15:0] pp_d_o
);

  // Widen both operands so an 8x8 product keeps all 16 bits.
  always_comb begin
    pp_a_o = 16'(a_i[7:0])   * 16'(bk_i);
    pp_b_o = 16'(a_i[15:8])  * 16'(bk_i);
    pp_c_o = 16'(a_i[23:16]) * 16'(bk_i);
    pp_d_o = 16'(a_i[31:24]) * 16'(bk_i);
  end

endmodule

// File: rtl/mult32_seq_acc.sv
// Sequential 32x32 unsigned multiplier controller.
// Each cycle it feeds four 8x8 lane products for one multiplier byte to an
// external row combiner. It then adds the combiner's 40-bit row sum, shifted
// by 8*k, into a 64-bit accumulator.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - mult32_seq_acc_if.slave (operand/result handshakes, pp_*, row_sum)
// Optional feature: defining MULT32_EARLY_EXIT_EN ends RUN once every
// multiplier byte that remains is zero. The product value does not change.
module mult32_seq_acc
  import mult32_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  mult32_seq_acc_if.slave    bus
);

  mult_state_t             state_q, state_d;
  logic [31:0]             a_q, a_d;
  logic [31:0]             b_q, b_d;
  logic [MULT_PROD_W-1:0]  acc_q, acc_d;
  logic [1:0]              k_q, k_d;

  logic [7:0]  bk;
  logic [15:0] lane_a, lane_b, lane_c, lane_d;
  logic        last_row;

  assign bk = b_q[{k_q, 3'b000} +: MULT_BYTE_W];

  pp_gen8x32 u_pp_gen (
    .a_i    (a_q),
    .bk_i   (bk),
    .pp_a_o (lane_a),
    .pp_b_o (lane_b),
    .pp_c_o (lane_c),
    .pp_d_o (lane_d)
  );

`ifdef MULT32_EARLY_EXIT_EN
  assign last_row = (k_q == 2'd3) || upper_bytes_zero(b_q, k_q);
`else
  assign last_row = (k_q == 2'd3);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.in_valid) state_d = StRun;
      StRun:   if (last_row) state_d = StDone;
      StDone:  if (bus.out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next state
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    acc_d = acc_q;
    k_d   = k_q;
    if (state_q == StIdle && bus.in_valid) begin
      a_d   = bus.a_in;
      b_d   = bus.b_in;
      acc_d = '0;
      k_d   = '0;
    end else if (state_q == StRun) begin
      // The true product is below 2^64, so this addition never carries out.
      acc_d = acc_q + (MULT_PROD_W'(bus.row_sum) << {k_q, 3'b000});
      k_d   = k_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      k_q   <= '0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      acc_q <= acc_d;
      k_q   <= k_d;
    end
  end

  // Outputs. Every output depends only on registers.
  always_comb begin
    bus.in_ready  = (state_q == StIdle);
    bus.out_valid = (state_q == StDone);
    bus.product   = (state_q == StDone) ? acc_q : '0;
    if (state_q == StRun) begin
      bus.pp_a = lane_a;
      bus.pp_b = lane_b;
      bus.pp_c = lane_c;
      bus.pp_d = lane_d;
    end else begin
      bus.pp_a = '0;
      bus.pp_b = '0;
      bus.pp_c = '0;
      bus.pp_d = '0;
    end
  end

endmodule

// File: tb/tb_mult32_seq_acc.sv
// Self-checking bench for mult32_seq_acc.
// It models the external row combiner and checks the DUT against plain
// 64-bit arithmetic. The checks cover lane products, latency, DONE stalls,
// back-to-back accepts and a reset in mid-RUN.
module tb_mult32_seq_acc;
  import mult32_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult32_seq_acc_if bus ();

  mult32_seq_acc dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Row combiner model: the weighted sum of the four lanes.
  assign bus.row_sum = 40'(bus.pp_a) + (40'(bus.pp_b) << 8) + (40'(bus.pp_c) << 16)
                     + (40'(bus.pp_d) << 24);

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] prod;
    int          stall;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Number of RUN cycles follows from the highest nonzero multiplier byte.
  function automatic int exp_lat(input logic [31:0] b);
`ifdef MULT32_EARLY_EXIT_EN
    int n = 1;
    for (int i = 0; i < 4; i++) begin
      if (((b >> (8 * i)) & 32'hFF) != 0) n = i + 1;
    end
    return n;
`else
    return 4;
`endif
  endfunction

  // Call at a negedge while idle. Returns at the negedge after the accept edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    chk("in_ready_idle", 64'(bus.in_ready), 64'd1);
    chk("out_valid_idle", 64'(bus.out_valid), 64'd0);
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input logic [31:0] a, input logic [31:0] b, output int lat);
    int cyc = 0;
    logic [15:0] bk;
    while (!bus.out_valid && cyc < 10) begin
      if (cyc < 4) begin
        bk = 16'((b >> (8 * cyc)) & 32'hFF);
        chk("pp_a", 64'(bus.pp_a), 64'(16'(a[7:0]) * bk));
        chk("pp_b", 64'(bus.pp_b), 64'(16'(a[15:8]) * bk));
        chk("pp_c", 64'(bus.pp_c), 64'(16'(a[23:16]) * bk));
        chk("pp_d", 64'(bus.pp_d), 64'(16'(a[31:24]) * bk));
      end
      chk("in_ready_run", 64'(bus.in_ready), 64'd0);
      cyc++;
      @(negedge clk);
    end
    chk("out_valid_done", 64'(bus.out_valid), 64'd1);
    lat = cyc;
  endtask

  // Call at a DONE negedge. Stalls, then completes the result handshake.
  task automatic finish_op(input logic [63:0] exp, input int stall);
    chk("product", bus.product, exp);
    chk("in_ready_done", 64'(bus.in_ready), 64'd0);
    chk("pp_zero_done", 64'({bus.pp_a, bus.pp_b, bus.pp_c, bus.pp_d}), 64'd0);
    bus.out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      bus.in_valid = 1'b1;
      bus.a_in     = $urandom;
      bus.b_in     = $urandom;
      @(negedge clk);
      chk("stall_valid", 64'(bus.out_valid), 64'd1);
      chk("stall_product", bus.product, exp);
      chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_hs_valid", 64'(bus.out_valid), 64'd0);
    chk("post_hs_in_ready", 64'(bus.in_ready), 64'd1);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [63:0] exp,
                        input int stall);
    int lat;
    start_op(a, b);
    wait_done(a, b, lat);
    chk("latency", 64'(lat), 64'(exp_lat(b)));
    finish_op(exp, stall);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic [31:0] ra, rb;

    vecs[0] = '{a: 32'h3,        b: 32'h5,        prod: 64'h000000000000000F, stall: 0};
    vecs[1] = '{a: 32'hFFFFFFFF, b: 32'hFFFFFFFF, prod: 64'hFFFFFFFE00000001, stall: 1};
    vecs[2] = '{a: 32'h12345678, b: 32'h9ABCDEF0, prod: 64'h0B00EA4E242D2080, stall: 0};
    vecs[3] = '{a: 32'h10,       b: 32'h7,        prod: 64'h70,               stall: 3};
    vecs[4] = '{a: 32'hDEADBEEF, b: 32'h0,        prod: 64'h0,                stall: 2};

    bus.in_valid  = 1'b0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);

    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_product", bus.product, 64'd0);
    chk("rst_pp", 64'({bus.pp_a, bus.pp_b, bus.pp_c, bus.pp_d}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].prod, vecs[i].stall);
    end

    // Back-to-back: in_valid stays high through the DONE handshake.
    start_op(vecs[2].a, vecs[2].b);
    wait_done(vecs[2].a, vecs[2].b, lat);
    chk("b2b_latency", 64'(lat), 64'(exp_lat(vecs[2].b)));
    chk("b2b_product", bus.product, vecs[2].prod);
    bus.a_in      = 32'hFFFFFFFF;
    bus.b_in      = 32'hFFFFFFFF;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    chk("b2b_in_ready_done", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_idle_valid", 64'(bus.out_valid), 64'd0);
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 0);

    // Reset during RUN row k=2 discards the operation.
    start_op(32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrun_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("midrun_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("midrun_rst_product", bus.product, 64'd0);
    chk("midrun_rst_pp", 64'({bus.pp_a, bus.pp_b, bus.pp_c, bus.pp_d}), 64'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_hold_valid", 64'(bus.out_valid), 64'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_valid", 64'(bus.out_valid), 64'd0);
    run_op(32'd2, 32'd2, 64'd4, 0);

    // Random operands. Upper multiplier bytes are sometimes zeroed.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = rb & 32'h000000FF;
        1: rb = rb & 32'h0000FFFF;
        2: rb = rb & 32'h00FFFFFF;
        3: ra = ra & 32'hFF00FF00;
        default: ;
      endcase
      run_op(ra, rb, 64'(ra) * 64'(rb), int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
